// File: rtl/ship_rom_arbiter_if.sv
// Request/response bundle between sprite renderers, the shared ship ROM and the arbiter.
// req/gnt: req[i] is held with a stable req_line slice until gnt[i] pulses; each cycle req stays high afterwards is a new request.
interface ship_rom_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int LINE_W = 9,
    parameter int DATA_W = 48
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*LINE_W-1:0] req_line;
    logic [N_REQ-1:0]        gnt;
    logic [LINE_W-1:0]       rom_line;
    logic [DATA_W-1:0]       rom_pixels;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_pixels;

    // master: renderers plus the ROM macro; slave: the arbiter
    modport master (
        output req, req_line, rom_pixels,
        input  gnt, rom_line, rsp_valid, rsp_id, rsp_pixels
    );
    modport slave (
        input  req, req_line, rom_pixels,
        output gnt, rom_line, rsp_valid, rsp_id, rsp_pixels
    );
endinterface

// File: rtl/ship_rom_arbiter.sv
// Round-robin arbiter sharing the single-port ship sprite ROM between sprite renderers.
// Two registered stages: grant/address, then tagged response with out-of-range lines masked.
module ship_rom_arbiter #(
    parameter int          N_REQ    = 4,
    parameter int          LINE_W   = 9,
    parameter int          DATA_W   = 48,
    parameter int unsigned LINE_MAX = 32'h020
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    ship_rom_arbiter_if.slave    bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [ID_W-1:0]    ptr;
    logic [2*N_REQ-1:0] rot;
    logic               win_found;
    logic [ID_W:0]      win_sum;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    nxt_ptr;
    logic [LINE_W-1:0]  win_line;
    logic               win_oob;

    logic [ID_W-1:0]    id1;
    logic               oob1;
    logic               oob2;

    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        rot       = {bus.req, bus.req} >> ptr;
        win_found = 1'b0;
        win_sum   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                win_found = 1'b1;
                win_sum   = {1'b0, ptr} + (ID_W+1)'(k);
            end
        end
        win_id   = (win_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(win_sum - (ID_W+1)'(N_REQ))
                                                 : ID_W'(win_sum);
        nxt_ptr  = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
        win_line = bus.req_line[int'(win_id)*LINE_W +: LINE_W];
        win_oob  = (win_line == '0) || (win_line > LINE_W'(LINE_MAX));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr           <= '0;
            bus.gnt       <= '0;
            bus.rom_line  <= '0;
            id1           <= '0;
            oob1          <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            oob2          <= 1'b0;
        end else begin
            // frame_start overrides the pointer advance but not this cycle's grant
            if (frame_start) begin
                ptr <= '0;
            end else if (win_found) begin
                ptr <= nxt_ptr;
            end

            bus.gnt <= win_found ? (N_REQ'(1) << win_id) : '0;
            if (win_found) begin
                bus.rom_line <= win_line;
                id1          <= win_id;
                oob1         <= win_oob;
            end

            bus.rsp_valid <= |bus.gnt;
            bus.rsp_id    <= id1;
            oob2          <= oob1;
        end
    end

    // ROM data is already registered by the macro; only the mask is applied here.
    assign bus.rsp_pixels = oob2 ? DATA_W'(0) : bus.rom_pixels;

endmodule

// File: tb/tb_ship_rom_arbiter.sv
// Directed bench for ship_rom_arbiter: cycle table plus hand-written corner sequences.
module tb_ship_rom_arbiter;
    localparam int N  = 4;
    localparam int LW = 9;
    localparam int DW = 48;

    typedef struct {
        logic        rst;
        logic        fs;
        logic [3:0]  req;
        logic [35:0] lines;
        logic [3:0]  gnt;
        logic [8:0]  line;
        logic        rv;
        logic [1:0]  id;
        logic [47:0] pix;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic sb_on = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [49:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    ship_rom_arbiter_if #(.N_REQ(N), .LINE_W(LW), .DATA_W(DW)) bus ();

    ship_rom_arbiter #(.N_REQ(N), .LINE_W(LW), .DATA_W(DW), .LINE_MAX(32'h020)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_start(frame_start),
        .bus(bus)
    );

    // ROM model; unlisted lines return nonzero so masking is observable
    function automatic logic [47:0] rom_lookup(input logic [8:0] a);
        case (a)
            9'd1:    rom_lookup = 48'h000000000000;
            9'd3:    rom_lookup = 48'h000000014000;
            9'd4:    rom_lookup = 48'h000000069000;
            9'd5:    rom_lookup = 48'h000000069000;
            9'd13:   rom_lookup = 48'h00001AAAA414;
            default: rom_lookup = {39'h2A5A5A5A5A, a};
        endcase
    endfunction

    always @(posedge clk) bus.rom_pixels <= rom_lookup(bus.rom_line);

    function automatic logic [35:0] lns(input logic [8:0] l3, l2, l1, l0);
        lns = {l3, l2, l1, l0};
    endfunction

    function automatic vec_t mkv(input logic r, f, input logic [3:0] q, input logic [35:0] l,
                                 input logic [3:0] g, input logic [8:0] ln, input logic v,
                                 input logic [1:0] id, input logic [47:0] px);
        vec_t t;
        t.rst = r; t.fs = f; t.req = q; t.lines = l;
        t.gnt = g; t.line = ln; t.rv = v; t.id = id; t.pix = px;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // driver
    task automatic drive(input logic r, input logic f, input logic [3:0] q, input logic [35:0] l);
        rst_n       = r;
        frame_start = f;
        bus.req     = q;
        bus.req_line = l;
    endtask

    // advance one cycle and let the scoreboard consume any response
    task automatic tick();
        logic [49:0] e;
        @(posedge clk);
        #1;
        if (sb_on && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_rsp", {63'd0, bus.rsp_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_rsp", {14'd0, bus.rsp_id, bus.rsp_pixels}, {14'd0, e});
            end
        end
    endtask

    initial begin
        vec_t v[20];
        logic [35:0] fa, la;

        fa = lns(9'd1, 9'd13, 9'd4, 9'd3);
        v[0]  = mkv(0, 0, 4'h0, 36'd0,                 4'h0, 9'h000, 0, 2'd0, 48'h0);
        v[1]  = mkv(1, 0, 4'h4, lns(0, 9'd4, 0, 0),    4'h4, 9'h004, 0, 2'd0, 48'h0);
        v[2]  = mkv(1, 0, 4'h0, lns(0, 9'd4, 0, 0),    4'h0, 9'h000, 1, 2'd2, 48'h000000069000);
        v[3]  = mkv(1, 1, 4'h0, 36'd0,                 4'h0, 9'h000, 0, 2'd0, 48'h0);
        v[4]  = mkv(1, 0, 4'hF, fa,                    4'h1, 9'h003, 0, 2'd0, 48'h0);
        v[5]  = mkv(1, 0, 4'hF, fa,                    4'h2, 9'h004, 1, 2'd0, 48'h000000014000);
        v[6]  = mkv(1, 0, 4'hF, fa,                    4'h4, 9'h00D, 1, 2'd1, 48'h000000069000);
        v[7]  = mkv(1, 0, 4'hF, fa,                    4'h8, 9'h001, 1, 2'd2, 48'h00001AAAA414);
        v[8]  = mkv(1, 0, 4'hF, fa,                    4'h1, 9'h003, 1, 2'd3, 48'h0);
        v[9]  = mkv(1, 0, 4'hF, fa,                    4'h2, 9'h004, 1, 2'd0, 48'h000000014000);
        v[10] = mkv(1, 0, 4'hF, fa,                    4'h4, 9'h00D, 1, 2'd1, 48'h000000069000);
        v[11] = mkv(1, 0, 4'hF, fa,                    4'h8, 9'h001, 1, 2'd2, 48'h00001AAAA414);
        v[12] = mkv(1, 0, 4'h0, fa,                    4'h0, 9'h000, 1, 2'd3, 48'h0);
        v[13] = mkv(1, 0, 4'h0, fa,                    4'h0, 9'h000, 0, 2'd0, 48'h0);
        v[14] = mkv(1, 0, 4'h1, lns(0, 0, 0, 9'h000),  4'h1, 9'h000, 0, 2'd0, 48'h0);
        v[15] = mkv(1, 0, 4'h1, lns(0, 0, 0, 9'h021),  4'h1, 9'h021, 1, 2'd0, 48'h0);
        v[16] = mkv(1, 0, 4'h1, lns(0, 0, 0, 9'h1FF),  4'h1, 9'h1FF, 1, 2'd0, 48'h0);
        v[17] = mkv(1, 0, 4'h1, lns(0, 0, 0, 9'h00D),  4'h1, 9'h00D, 1, 2'd0, 48'h0);
        v[18] = mkv(1, 0, 4'h0, lns(0, 0, 0, 9'h00D),  4'h0, 9'h000, 1, 2'd0, 48'h00001AAAA414);
        v[19] = mkv(1, 0, 4'h0, lns(0, 0, 0, 9'h00D),  4'h0, 9'h000, 0, 2'd0, 48'h0);

        drive(0, 0, 4'h0, 36'd0);
        tick();
        tick();

        for (int i = 0; i < 20; i++) begin
            drive(v[i].rst, v[i].fs, v[i].req, v[i].lines);
            tick();
            chk($sformatf("v%0d_gnt", i), {60'd0, bus.gnt}, {60'd0, v[i].gnt});
            if (v[i].gnt != 4'h0 || !v[i].rst)
                chk($sformatf("v%0d_rom_line", i), {55'd0, bus.rom_line}, {55'd0, v[i].line});
            chk($sformatf("v%0d_rsp_valid", i), {63'd0, bus.rsp_valid}, {63'd0, v[i].rv});
            if (v[i].rv || !v[i].rst)
                chk($sformatf("v%0d_rsp_id", i), {62'd0, bus.rsp_id}, {62'd0, v[i].id});
            if (v[i].rv)
                chk($sformatf("v%0d_rsp_pixels", i), {16'd0, bus.rsp_pixels}, {16'd0, v[i].pix});
        end

        sb_on = 1'b1;

        // frame_start coincident with a grant to 2 (ptr is 1 here)
        la = lns(0, 9'd4, 9'd5, 9'd3);
        drive(1, 1, 4'b1100, la); exp_q.push_back({2'd2, 48'h000000069000});
        tick(); chk("fs_gnt2_a", {60'd0, bus.gnt}, 64'h4);
        drive(1, 0, 4'b1001, la); exp_q.push_back({2'd0, 48'h000000014000});
        tick(); chk("fs_next_is_0", {60'd0, bus.gnt}, 64'h1);
        drive(1, 1, 4'b1100, la); exp_q.push_back({2'd2, 48'h000000069000});
        tick(); chk("fs_gnt2_b", {60'd0, bus.gnt}, 64'h4);
        drive(1, 0, 4'b1010, la); exp_q.push_back({2'd1, 48'h000000069000});
        tick(); chk("fs_next_is_1", {60'd0, bus.gnt}, 64'h2);
        drive(1, 0, 4'h0, la);
        tick(); tick(); tick();
        chk("fs_drain", 64'(exp_q.size()), 64'd0);

        // reset in the cycle after a grant drops the response
        la = lns(0, 0, 9'd4, 9'd13);
        drive(1, 0, 4'b0010, la);
        tick(); chk("rst_gnt1", {60'd0, bus.gnt}, 64'h2);
        drive(0, 0, 4'h0, la);
        tick();
        chk("rst_gnt0", {60'd0, bus.gnt}, 64'd0);
        chk("rst_rom_line0", {55'd0, bus.rom_line}, 64'd0);
        chk("rst_rsp_valid0", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_rsp_id0", {62'd0, bus.rsp_id}, 64'd0);
        drive(1, 0, 4'h0, la);
        tick(); chk("rst_no_rsp_a", {63'd0, bus.rsp_valid}, 64'd0);
        tick(); chk("rst_no_rsp_b", {63'd0, bus.rsp_valid}, 64'd0);
        drive(1, 0, 4'hF, la); exp_q.push_back({2'd0, 48'h00001AAAA414});
        tick(); chk("rst_ptr0", {60'd0, bus.gnt}, 64'h1);
        drive(1, 0, 4'h0, la);
        tick(); tick();
        chk("rst_drain", 64'(exp_q.size()), 64'd0);

        // back-to-back grants to one requester, lines 1 -> 3 -> 5
        drive(1, 0, 4'b0010, lns(0, 0, 9'd1, 0)); exp_q.push_back({2'd1, 48'h000000000000});
        tick(); chk("b2b_gnt_a", {60'd0, bus.gnt}, 64'h2); chk("b2b_line_a", {55'd0, bus.rom_line}, 64'd1);
        drive(1, 0, 4'b0010, lns(0, 0, 9'd3, 0)); exp_q.push_back({2'd1, 48'h000000014000});
        tick(); chk("b2b_gnt_b", {60'd0, bus.gnt}, 64'h2); chk("b2b_line_b", {55'd0, bus.rom_line}, 64'd3);
        drive(1, 0, 4'b0010, lns(0, 0, 9'd5, 0)); exp_q.push_back({2'd1, 48'h000000069000});
        tick(); chk("b2b_gnt_c", {60'd0, bus.gnt}, 64'h2); chk("b2b_line_c", {55'd0, bus.rom_line}, 64'd5);
        drive(1, 0, 4'h0, lns(0, 0, 9'd5, 0));
        tick(); chk("b2b_gnt_off", {60'd0, bus.gnt}, 64'd0);
        tick(); tick();
        chk("b2b_drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ship_rom_arbiter.md
# ship_rom_arbiter

Round-robin arbiter that shares the single-port, 2-bit-per-pixel ship sprite ROM (32 lines × 48 bits, registered output) between several sprite renderers, e.g. player-board and enemy-board ship drawers. It takes line-read requests and issues at most one ROM address per clock. It returns the ROM line to the winning requester with a tagged valid pulse. Out-of-range lines are masked to transparent (all-zero) pixels.

## Interface
- N_REQ, 4: number of requesters (2..8)
- LINE_W, 9: ROM line address width
- DATA_W, 48: ROM line width (24 pixels × 2 bit)
- LINE_MAX, 9'h020: highest valid ROM line; valid range is 1..LINE_MAX

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- frame_start  in  1  one-cycle pulse at start of frame; resets round-robin pointer
- req  in  N_REQ  per-requester read request, held until granted
- req_line  in  N_REQ*LINE_W  packed line addresses; requester i uses bits [i*LINE_W +: LINE_W]
- gnt  out  N_REQ  one-hot grant pulse, one cycle
- rom_line  out  LINE_W  address to ROM line input
- rom_pixels  in  DATA_W  ROM registered output
- rsp_valid  out  1  response data valid
- rsp_id  out  $clog2(N_REQ)  index of requester owning the response
- rsp_pixels  out  DATA_W  returned line pixels

## Operation
- Arbitration is combinational over req and pointer `ptr`.
  - Winner is the first asserted req[i] scanning i = ptr, ptr+1, … modulo N_REQ.
  - The winner is registered at the next edge.
- After a grant to i, ptr ← (i+1) mod N_REQ. With no request, ptr holds.
- frame_start has priority over the ptr update: ptr ← 0 at that edge. Arbitration in the same cycle still uses the old ptr, and the grant is still issued.
- Requester protocol:
  - Assert req[i] with a stable req_line slice.
  - Deassert in the cycle after seeing gnt[i], or keep req high to request another line. Each cycle with req high after a gnt counts as a new request.
- Pipeline (registered stages):
  - S1: gnt, rom_line, id1, oob1.
  - S2: rsp_valid, rsp_id, oob2. rsp_pixels = oob2 ? 0 : rom_pixels, a combinational mux on the ROM register.
- oob1 = (line == 0) || (line > LINE_MAX). rom_line is still driven for OOB lines, but the data is discarded.
- Throughput: one grant per cycle, with no bubbles under continuous requests.
- Reset values (rst_n low at an edge): gnt=0, rom_line=0, rsp_valid=0, rsp_id=0, ptr=0, id1/oob pipeline cleared.
  - Reset mid-operation drops all in-flight responses; no rsp_valid follows reset.
- Width rule: the req_line slice is used unmodified; no truncation or wrap of the line address.

## Timing
- Edge E0 samples req and drives gnt[i]=1 and rom_line for one cycle after E0.
- The ROM registers rom_pixels at E1. rsp_valid=1 and rsp_id=i appear after E1, with rsp_pixels valid in the same cycle.
- Latency is 2 cycles from req sampled to rsp_valid.
- rsp_valid is high for exactly one cycle per grant.
- gnt is never asserted for a requester whose req was low at E0.
- gnt has at most one bit set.

## Test plan
- Single request: req[2]=1, line 9'h004 → gnt=4'b0100 one cycle later; rsp_valid, rsp_id=2 and rsp_pixels=48'h000000069000 two cycles after sampling.
- Fairness: all four req held high for 8 cycles with ptr=0 → grant order 0,1,2,3,0,1,2,3; rsp_id follows the same sequence two cycles behind, with no gaps.
- Out of range: line 9'h000, then 9'h021, then 9'h1FF → rsp_valid each time, rsp_pixels=0. A following line 9'h00D returns 48'h00001AAAA414.
- frame_start coincident with a grant to 2: req={3,2} asserted → grant to 2 in that cycle; ptr=0, so the next grant goes to 0 if req[0] is high, else 1.
- Reset mid-flight: rst_n low in the cycle after gnt → no rsp_valid follows; all outputs 0 after the reset edge; ptr=0.
- Back-to-back same requester: req[1] held high for 3 cycles, lines 1→3→5 → three gnt pulses and three responses with 48'h0, 48'h000000014000, 48'h000000069000 in order.
